// File: rtl/add4b_nibble_seq_if.sv
// Operand/result handshakes plus the nibble-wide adder port of add4b_nibble_seq.
// The out_ovf signal exists only when ADD4B_SEQ_OVF_EN is defined.
interface add4b_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;

  logic         add_en;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic         add_cout;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef ADD4B_SEQ_OVF_EN
  logic         out_ovf;
`endif

  // master is the surrounding environment: operand source, adder and result sink
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    input  in_ready, add_en, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef ADD4B_SEQ_OVF_EN
    , out_ovf
`endif
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_s, add_cout,
    output in_ready, add_en, add_a, add_b, add_cin, out_valid, out_sum, out_cout
`ifdef ADD4B_SEQ_OVF_EN
    , out_ovf
`endif
  );
endinterface

// File: rtl/add4b_nibble_seq.sv
// Serialises a wide add onto an external combinational 4-bit adder, one nibble per clock.
// Define ADD4B_SEQ_OVF_EN to add the registered signed-overflow flag out_ovf.
module add4b_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  add4b_nibble_seq_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_next;
  logic [W-1:0]  sum_q;
  logic          cout_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          add_en_q;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
`ifdef ADD4B_SEQ_OVF_EN
  logic          ovf_q;
`endif

  // acc is a working copy; out_sum only changes when a whole result completes
  always_comb begin
    nib_a    = opa[{idx, 2'b00} +: 4];
    nib_b    = opb[{idx, 2'b00} +: 4];
    acc_next = acc;
    acc_next[{idx, 2'b00} +: 4] = bus.add_s;
  end

  assign bus.add_en    = add_en_q;
  assign bus.add_a     = add_en_q ? nib_a : 4'h0;
  assign bus.add_b     = add_en_q ? nib_b : 4'h0;
  assign bus.add_cin   = add_en_q ? carry : 1'b0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
`ifdef ADD4B_SEQ_OVF_EN
  assign bus.out_ovf   = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      add_en_q    <= 1'b0;
`ifdef ADD4B_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            opa        <= bus.in_a;
            opb        <= bus.in_b;
            carry      <= bus.in_cin;
            idx        <= '0;
            acc        <= '0;
            in_ready_q <= 1'b0;
            add_en_q   <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= bus.add_cout;
          if (idx == LAST) begin
            sum_q       <= acc_next;
            cout_q      <= bus.add_cout;
`ifdef ADD4B_SEQ_OVF_EN
            ovf_q       <= (opa[W-1] == opb[W-1]) && (bus.add_s[3] != opa[W-1]);
`endif
            add_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so a same-cycle in_valid waits one cycle
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_add4b_nibble_seq.sv
// Randomised self-checking bench for add4b_nibble_seq; models the 4-bit adder and
// predicts results with plain wide arithmetic.
module tb_add4b_nibble_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   first_cyc;
  logic [4:0] add_full;

  add4b_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

  add4b_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // the combinational 4-bit adder the block drives
  assign add_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_cin};
  assign bus.add_s    = add_full[3:0];
  assign bus.add_cout = add_full[4];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // carry entering nibble k = carry out of the low 4*k bits of a+b+cin
  function automatic logic carryInto(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input int k);
    logic [W-1:0] m;
    logic [W:0]   lo;
    m  = (k == 0) ? '0 : ({W{1'b1}} >> (W - 4 * k));
    lo = {1'b0, a & m} + {1'b0, b & m} + {{W{1'b0}}, cin};
    return lo[4 * k];
  endfunction

  task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int waited = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc;
  endtask

  task automatic finishOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int stall);
    logic [W:0] r;
    int edges = 0;
    r = refAdd(a, b, cin);
    bus.out_ready = (stall == 0);
    while (!bus.out_valid && edges < 4 * NIBBLES + 8) begin
      if (edges < NIBBLES) begin
        checkOutput("run_add_en", 64'(bus.add_en), 64'd1);
        checkOutput("run_add_a", 64'(bus.add_a), 64'(a[4*edges +: 4]));
        checkOutput("run_add_b", 64'(bus.add_b), 64'(b[4*edges +: 4]));
        checkOutput("run_add_cin", 64'(bus.add_cin), 64'(carryInto(a, b, cin, edges)));
        checkOutput("run_in_ready", 64'(bus.in_ready), 64'd0);
      end
      @(negedge clk);
      edges++;
    end
    checkOutput("latency", 64'(edges), 64'(NIBBLES));
    checkOutput("sum", 64'(bus.out_sum), 64'(r[W-1:0]));
    checkOutput("cout", 64'(bus.out_cout), 64'(r[W]));
`ifdef ADD4B_SEQ_OVF_EN
    checkOutput("ovf", 64'(bus.out_ovf),
                64'((a[W-1] == b[W-1]) && (r[W-1] != a[W-1])));
`endif
    checkOutput("done_add_en", 64'(bus.add_en), 64'd0);
    checkOutput("done_add_a", 64'(bus.add_a), 64'd0);
    checkOutput("done_add_cin", 64'(bus.add_cin), 64'd0);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("hold_sum", 64'(bus.out_sum), 64'(r[W-1:0]));
      checkOutput("hold_cout", 64'(bus.out_cout), 64'(r[W]));
      checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    if (stall > 0) bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("release_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("release_sum_held", 64'(bus.out_sum), 64'(r[W-1:0]));
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               input int stall);
    startOp(a, b, cin);
    bus.in_valid = 1'b0;
    finishOp(a, b, cin, stall);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_out_sum"}, 64'(bus.out_sum), 64'd0);
    checkOutput({tag, "_out_cout"}, 64'(bus.out_cout), 64'd0);
    checkOutput({tag, "_add_en"}, 64'(bus.add_en), 64'd0);
    checkOutput({tag, "_add_a"}, 64'(bus.add_a), 64'd0);
    checkOutput({tag, "_add_cin"}, 64'(bus.add_cin), 64'd0);
`ifdef ADD4B_SEQ_OVF_EN
    checkOutput({tag, "_out_ovf"}, 64'(bus.out_ovf), 64'd0);
`endif
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(16'h1234, 16'h1111, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 0);
    applyStimulus(16'hABCD, 16'h1000, 1'b0, 3);

    $display("[TB] reset in the middle of an operation");
    startOp(16'h1357, 16'h2468, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("midrst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("midrst_hold_valid", 64'(bus.out_valid), 64'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    end
    applyStimulus(16'h0002, 16'h0003, 1'b0, 0);

    $display("[TB] back-to-back with in_valid held");
    startOp(16'h0F0F, 16'h00F1, 1'b1);
    first_cyc  = accept_cyc;
    bus.in_a   = 16'h8000;
    bus.in_b   = 16'h8001;
    bus.in_cin = 1'b0;
    finishOp(16'h0F0F, 16'h00F1, 1'b1, 0);
    startOp(16'h8000, 16'h8001, 1'b0);
    checkOutput("b2b_gap", 64'(accept_cyc - first_cyc), 64'(NIBBLES + 2));
    bus.in_valid = 1'b0;
    finishOp(16'h8000, 16'h8001, 1'b0, 0);

    $display("[TB] random operations");
    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
